// File: rtl/collision_event_arbiter_pkg.sv
// Shared definitions for the collision event arbiter: source indices,
// default sizing and the arbiter state encoding.
package collision_event_arbiter_pkg;

    localparam int NUM_COLLISION_SRC      = 4;
    localparam int HOLDOFF_FRAMES_DEFAULT = 2;
    localparam int DROP_W                 = 4;

    typedef enum logic [1:0] {
        SRC_BORDER_BOTTOM = 2'd0,
        SRC_OBSTACLE_BAD  = 2'd1,
        SRC_OBSTACLE_GOOD = 2'd2,
        SRC_BONUS         = 2'd3
    } collision_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_OFFER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/collision_event_arbiter_lsb_priority_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module collision_event_arbiter_lsb_priority_encoder #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         vec,
    output logic [$clog2(NUM_SRC)-1:0] idx,
    output logic                       any
);

    always_comb begin
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = $clog2(NUM_SRC)'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/collision_event_arbiter.sv
// Turns per-frame collision pulses into at most one prioritized event per frame,
// with first-frame filtering, per-source hold-off and a valid/ready handshake.
module collision_event_arbiter
    import collision_event_arbiter_pkg::*;
#(
    parameter int NUM_SRC        = NUM_COLLISION_SRC,
    parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic                       pause,
    input  logic                       flush,
    input  logic [NUM_SRC-1:0]         collision_req,
    input  logic                       event_ready,
    output logic                       event_valid,
    output logic [$clog2(NUM_SRC)-1:0] event_src,
    output logic [DROP_W-1:0]          dropped_count
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    function automatic int unsigned popcount(input logic [NUM_SRC-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        return (s > 32'((1 << DROP_W) - 1)) ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

    arb_state_e          state_q, state_d;
    logic [NUM_SRC-1:0]  latch_q, latch_d;
    logic [NUM_SRC-1:0]  snap_q, snap_d;
    logic [NUM_SRC-1:0]  prev_q, prev_d;
    logic [HOLD_W-1:0]   hold_q [NUM_SRC];
    logic [HOLD_W-1:0]   hold_d [NUM_SRC];
    logic                valid_q, valid_d;
    logic [IDX_W-1:0]    src_q, src_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                sof_pend_q, sof_pend_d;

    logic [NUM_SRC-1:0]  req_live;
    logic [NUM_SRC-1:0]  snap_now;
    logic [NUM_SRC-1:0]  hold_active;
    logic [NUM_SRC-1:0]  new_arb;
    logic [NUM_SRC-1:0]  new_offer;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic                eff_sof;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            hold_active[i] = (hold_q[i] != '0);
        end
    end

    assign req_live  = collision_req & ~{NUM_SRC{pause}};
    assign snap_now  = latch_q | req_live;
    assign new_arb   = snap_q & ~prev_q & ~hold_active;
    assign new_offer = snap_now & ~prev_q & ~hold_active;
    // A frame boundary seen during ARB is replayed on the following cycle.
    assign eff_sof   = (startOfFrame && (state_q != ST_ARB)) || sof_pend_q;

    collision_event_arbiter_lsb_priority_encoder #(
        .NUM_SRC(NUM_SRC)
    ) u_enc (
        .vec(new_arb),
        .idx(win_idx),
        .any(win_any)
    );

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        prev_d     = prev_q;
        valid_d    = valid_q;
        src_d      = src_q;
        drop_d     = drop_q;
        sof_pend_d = startOfFrame && (state_q == ST_ARB);
        latch_d    = eff_sof ? '0 : (latch_q | req_live);
        for (int i = 0; i < NUM_SRC; i++) begin
            hold_d[i] = hold_q[i];
            if (eff_sof && !pause && hold_active[i]) begin
                hold_d[i] = hold_q[i] - HOLD_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (eff_sof) begin
                    snap_d  = snap_now;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                prev_d = snap_q;
                if (win_any) begin
                    src_d   = win_idx;
                    drop_d  = sat_add(drop_q, popcount(new_arb) - 1);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                // Everything new in a frame that ends while an event is pending is dropped.
                if (eff_sof) begin
                    prev_d = snap_now;
                    drop_d = sat_add(drop_q, popcount(new_offer));
                end
                if (event_ready) begin
                    hold_d[src_q] = HOLD_W'(HOLDOFF_FRAMES);
                    valid_d       = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            latch_d    = '0;
            prev_d     = '0;
            sof_pend_d = 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            latch_q    <= '0;
            snap_q     <= '0;
            prev_q     <= '0;
            valid_q    <= 1'b0;
            src_q      <= '0;
            drop_q     <= '0;
            sof_pend_q <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            latch_q    <= latch_d;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            valid_q    <= valid_d;
            src_q      <= src_d;
            drop_q     <= drop_d;
            sof_pend_q <= sof_pend_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign event_valid   = valid_q;
    assign event_src     = src_q;
    assign dropped_count = drop_q;

endmodule

// File: doc/collision_event_arbiter.md
# collision_event_arbiter

Collects per-frame collision pulses from the drawing/collision detectors and converts them into at most one registered, prioritized game event per frame. Sits between the collision detectors and the game controller. Filters multi-frame overlaps to their first frame, applies a per-source hold-off, and offers the winner over a valid/ready handshake. The game controller therefore sees one clean event per frame instead of raw, overlapping pixel-level collisions.

## Interface
Parameters:
- NUM_SRC, 4, number of collision sources (index 0 = highest priority)
- HOLDOFF_FRAMES, 2, frames a source is ignored after its event is accepted (0 = no hold-off)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- pause  in  1  game paused; freezes latching and hold-off counting
- flush  in  1  synchronous clear, driven from the controller's level reset
- collision_req  in  NUM_SRC  raw collision pulses/levels from detectors
- event_ready  in  1  consumer accepts the offered event
- event_valid  out  1  event offered
- event_src  out  $clog2(NUM_SRC)  index of offered source
- dropped_count  out  4  saturating count of suppressed new collisions

## Operation
- Reset values: state IDLE; event_valid 0; event_src 0; dropped_count 0; frame latches, prev snapshot and hold-off counters all 0.
- Frame latch: latch[i] is set when collision_req[i]=1 and pause=0. Latches clear on startOfFrame.
- States:
  - IDLE: on startOfFrame go to ARB. Take snapshot = latch | (collision_req & ~pause). Clear latches.
  - ARB (1 cycle): new = snapshot & ~prev & ~holdoff_active. Then prev <= snapshot.
    - new == 0: go to IDLE.
    - Otherwise: event_src <= index of lowest set bit of new; dropped_count += popcount(new) − 1, saturating at 15; go to OFFER.
  - OFFER: event_valid = 1 and event_src held stable.
    - On event_ready: load hold-off[event_src] with HOLDOFF_FRAMES, then go to IDLE.
- startOfFrame in OFFER:
  - Snapshot, latch clear and prev update happen as normal.
  - All new bits of that frame are added to dropped_count (saturating). No new grant is made.
  - Stay in OFFER unless event_ready is also high that cycle; in that case go to IDLE.
- Hold-off: each nonzero counter decrements on startOfFrame when pause=0. holdoff_active[i] = (counter[i] != 0). A load on the same edge overrides the decrement.
- Pause: the OFFER state and its handshake still complete normally while paused.
- flush: next cycle the block is in IDLE with event_valid 0 and latches, prev and hold-off counters cleared. dropped_count is kept. flush has priority over all other inputs.

## Timing
- Collision at cycle t with startOfFrame at cycle s ≥ t: ARB in cycle s+1, event_valid high from s+2.
- Minimum latency from startOfFrame to event_valid is 2 cycles.
- A transfer occurs on the rising edge where event_valid && event_ready. event_valid is low the following cycle.
- event_ready while event_valid=0 is ignored.
- startOfFrame pulses are guaranteed ≥ 3 cycles apart. If a startOfFrame lands in ARB, it is handled as in IDLE after ARB completes, one cycle late.
- collision_req in the same cycle as startOfFrame belongs to the ending frame.

## Structure
- Shared package defines:
  - NUM_COLLISION_SRC.
  - Source index enum: SRC_BORDER_BOTTOM=0, SRC_OBSTACLE_BAD=1, SRC_OBSTACLE_GOOD=2, SRC_BONUS=3.
  - HOLDOFF_FRAMES_DEFAULT.
  - Arbiter state enum.
- One sub-module: lsb_priority_encoder (NUM_SRC-bit vector in; index and any-set flag out; purely combinational).
- popcount is an inline function.

## Test plan
- Reset mid-OFFER → event_valid drops to 0 immediately; all counters 0; dropped_count 0.
- collision_req=4'b0100 for one cycle, then startOfFrame → event_valid at +2 cycles with event_src=2. Ready held high → valid low the next cycle.
- collision_req=4'b1011 in one frame → event_src=0 and dropped_count=2. Same 4'b1011 held into the next frame → no event (prev filter).
- Source 2 accepted; it collides again in each of the next 3 frames with HOLDOFF_FRAMES=2 → no events in frames +1 and +2. Frame +3 also gives no event, because prev still holds bit 2. A gap frame followed by a re-collision → event.
- event_ready held low across 2 startOfFrame pulses, with new bit 1 set each frame → event_src stays 0 and dropped_count increments by 1 per frame, saturating at 15 after repeated frames.
- flush asserted during OFFER with pause=1 → IDLE next cycle; event_valid 0; a subsequent collision is accepted with no hold-off.
